div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 26 ++
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// div_unit_if : execute-stage <-> divider handshake and operand bundle
// Revision    : 1.0
// ============================================================================
interface div_unit_if;
  logic        start;
  logic        sign;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  modport master (
    output start, sign, annul, a, b,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, sign, annul, a, b,
    output result, ready, stall_req
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// div_unit : 32-bit radix-2 restoring divider (DIV/DIVU) for the HI/LO path
// Revision : 1.0
// ============================================================================
module div_unit (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_DZERO = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] a_q, a_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;

  logic [31:0] a_mag, b_mag;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [63:0] rem_step;
  logic [31:0] q_fix, r_fix;
  logic        accept;

  assign accept = bus.start & ~bus.annul;
  assign a_mag  = (bus.sign & bus.a[31]) ? -bus.a : bus.a;
  assign b_mag  = (bus.sign & bus.b[31]) ? -bus.b : bus.b;

  // Shifted value is the 65-bit partial remainder; its top 33 bits face the divisor.
  assign shifted  = {rem_q, 1'b0};
  assign diff     = shifted[64:32] - {1'b0, dvs_q};
  assign rem_step = diff[32] ? shifted[63:0] : {diff[31:0], shifted[31:1], 1'b1};
  assign q_fix    = qneg_q ? -rem_step[31:0]  : rem_step[31:0];
  assign r_fix    = rneg_q ? -rem_step[63:32] : rem_step[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d    = bus.a;
          dvs_d  = b_mag;
          rem_d  = {32'h0, a_mag};
          qneg_d = bus.sign & (bus.a[31] ^ bus.b[31]);
          rneg_d = bus.sign & bus.a[31];
          cnt_d  = 5'd0;
          state_d = (bus.b == 32'h0) ? S_DZERO : S_ON;
        end
      end
      S_ON: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = {r_fix, q_fix};
            state_d  = S_DONE;
          end
        end
      end
      S_DZERO: begin
        if (bus.annul) begin
          state_d = S_IDLE;
        end else begin
          result_d = {a_q, 32'hFFFF_FFFF};
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 64'h0;
      dvs_q    <= 32'h0;
      a_q      <= 32'h0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.ready     = (state_q == S_DONE);
  // Released in DONE so the pipeline advances in the same cycle as ready.
  assign bus.stall_req = ((state_q == S_IDLE) & accept) | (state_q == S_ON) | (state_q == S_DZERO);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// tb_div_unit : scoreboard bench for div_unit against an arithmetic model
// Revision    : 1.0
// ============================================================================
module tb_div_unit;

  logic clk;
  logic resetn;
  div_unit_if bus ();

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, sign-aware via 64-bit arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'h0, x});
      sy = longint'({32'h0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (resetn && bus.ready) begin
        if (exp_q.size() == 0) begin
          chk("ready_without_request", {63'h0, bus.ready}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e);
        end
      end
    end
  end

  task automatic run_div(input logic [31:0] da, input logic [31:0] db, input logic ds, input bit scramble);
    int cyc;
    bit got;
    int lat;
    lat = (db == 32'h0) ? 2 : 33;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = da;
    bus.b     = db;
    bus.sign  = ds;
    exp_q.push_back(ref_div(da, db, ds));
    #1;
    chk("stall_on_start", {63'h0, bus.stall_req}, 64'h1);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (scramble) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (bus.ready) got = 1;
      else if (bus.stall_req !== 1'b1) chk("stall_busy", {63'h0, bus.stall_req}, 64'h1);
    end
    chk("latency", 64'(cyc), 64'(lat));
    if (got) chk("stall_at_ready", {63'h0, bus.stall_req}, 64'h0);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.annul = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    resetn    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_result", bus.result, 64'h0);
    chk("reset_ready", {63'h0, bus.ready}, 64'h0);
    chk("reset_stall", {63'h0, bus.stall_req}, 64'h0);
    resetn = 1'b1;

    // start is ignored while annul is high
    @(negedge clk);
    bus.start = 1'b1; bus.annul = 1'b1; bus.a = 32'd5; bus.b = 32'd1;
    #1 chk("annul_blocks_stall", {63'h0, bus.stall_req}, 64'h0);
    @(negedge clk);
    chk("annul_blocks_accept", {63'h0, bus.stall_req}, 64'h0);
    bus.start = 1'b0; bus.annul = 1'b0;

    run_div(32'd7, 32'd2, 1'b0, 0);
    chk("dir_7_2", ref_div(32'd7, 32'd2, 1'b0), {32'h1, 32'h3});
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0, 0);
    run_div(32'h1234_5678, 32'h0, 1'b1, 0);
    run_div(32'h1234_5678, 32'h0, 1'b0, 0);
    run_div(32'd7, 32'd2, 1'b0, 0);

    // Annul mid-iteration: no ready, result retained
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.sign = 1'b0;
    repeat (10) @(negedge clk);
    bus.annul = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    bus.annul = 1'b0;
    chk("annul_idle_stall", {63'h0, bus.stall_req}, 64'h0);
    repeat (40) @(negedge clk);
    chk("annul_keeps_result", bus.result, {32'h1, 32'h3});
    run_div(32'd100, 32'd7, 1'b0, 0);

    // Reset mid-operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.sign = 1'b0;
    repeat (20) @(negedge clk);
    resetn = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("midrst_result", bus.result, 64'h0);
    chk("midrst_ready", {63'h0, bus.ready}, 64'h0);
    chk("midrst_stall", {63'h0, bus.stall_req}, 64'h0);
    resetn = 1'b1;
    run_div(32'd9, 32'd3, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4:       rb = 32'h0000_FFFF & $urandom;
        default: rb = $urandom;
      endcase
      run_div(ra, rb, 1'($urandom_range(0, 1)), 1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
